// File: rtl/sysmon_pkg.sv
// Shared definitions for the system monitor UART link (RX dispatcher and TX arbiter).
//   SYSMON_SYNC   : frame start byte
//   SYSMON_ADDR_W : width of the channel address field (also used for tx_address)
//   sysmon_rx_state_e : RX frame parser states
package sysmon_pkg;

    localparam logic [7:0] SYSMON_SYNC   = 8'hA5;
    localparam int         SYSMON_ADDR_W = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK
    } sysmon_rx_state_e;

    // Saturating 8-bit increment used by the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sysmon_rx_timeout.sv
// Inter-byte timeout for the RX frame parser.
// Loadable down-counter: reloads to TIMEOUT_CYC-1 on kick or while disabled,
// counts down while enabled, and flags expire in the cycle it sits at zero
// with no kick. Expire at zero equals an up-count reaching TIMEOUT_CYC-1.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   enable       : parser is inside a frame
//   kick         : a byte arrived this cycle (suppresses expire)
//   expire       : frame must be aborted on this edge
module sysmon_rx_timeout #(
    parameter  int TIMEOUT_CYC = 50000,
    localparam int CW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    // "Cleared" in down-counter terms means sitting at the reload value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= LOAD;
        else if (kick || !enable || (r_cnt == '0))
            r_cnt <= LOAD;
        else
            r_cnt <= r_cnt - 1'b1;
    end

    assign expire = enable && !kick && (r_cnt == '0);

endmodule

// File: rtl/system_monitor_rx_dispatcher.sv
// System monitor RX dispatcher: parses SYNC/ADDR/payload[/CHK] frames from the
// UART byte stream and commits each valid frame as a one-cycle channel write
// plus an ack carrying the address.
// Optional feature macro: SYSMON_RX_CHECKSUM_EN (adds the XOR checksum byte).
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   rx_data, rx_valid     : received byte strobe (no backpressure)
//   ch_wr, ch_wr_channel, ch_wr_data : channel register write (data/channel held)
//   ack_valid, ack_addr   : commit ack, coincident with ch_wr
//   busy                  : parser is inside a frame
//   err_count             : saturating count of rejected/aborted frames
module system_monitor_rx_dispatcher
    import sysmon_pkg::*;
#(
    parameter  int NUM_CH      = 8,
    parameter  int DATA_W      = 32,
    parameter  int TIMEOUT_CYC = 50000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     ch_wr,
    output logic [CH_W-1:0]          ch_wr_channel,
    output logic [DATA_W-1:0]        ch_wr_data,
    output logic                     ack_valid,
    output logic [SYSMON_ADDR_W-1:0] ack_addr,
    output logic                     busy,
    output logic [7:0]               err_count
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    sysmon_rx_state_e         r_state;
    logic                     r_busy;
    logic                     r_wr;
    logic [IDX_W-1:0]         r_idx;
    logic [SYSMON_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]        r_asm;
    logic [CH_W-1:0]          r_ch;
    logic [DATA_W-1:0]        r_data;
    logic [SYSMON_ADDR_W-1:0] r_ack_addr;
    logic [7:0]               r_err;
`ifdef SYSMON_RX_CHECKSUM_EN
    logic [7:0]               r_xor;
`endif

    logic              w_expire;
    logic              w_addr_bad;
    logic              w_last;
    logic [DATA_W-1:0] w_asm;

    sysmon_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (r_busy),
        .kick    (rx_valid),
        .expire  (w_expire)
    );

    // Bit 7 set or an address past the last channel (covers non-power-of-2 NUM_CH).
    assign w_addr_bad = rx_data[7] || (32'(rx_data[6:0]) >= 32'(NUM_CH));
    assign w_last     = (32'(r_idx) == NBYTES - 1);

    // Assembly register with the current byte merged in, so a commit on the
    // last payload byte already carries that byte.
    always_comb begin
        w_asm = r_asm;
        w_asm[{r_idx, 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_wr       <= 1'b0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_asm      <= '0;
            r_ch       <= '0;
            r_data     <= '0;
            r_ack_addr <= '0;
            r_err      <= '0;
`ifdef SYSMON_RX_CHECKSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_wr <= 1'b0;
            // A byte in the expiry cycle wins: the timeout module masks expire on kick.
            if (rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == SYSMON_SYNC) begin
                            r_state <= S_ADDR;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        if (w_addr_bad) begin
                            r_err   <= sat_inc8(r_err);
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_addr  <= rx_data[SYSMON_ADDR_W-1:0];
                            r_idx   <= '0;
`ifdef SYSMON_RX_CHECKSUM_EN
                            r_xor   <= rx_data;
`endif
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // 0xA5 here is plain payload; no resync.
                        r_asm <= w_asm;
                        r_idx <= r_idx + 1'b1;
`ifdef SYSMON_RX_CHECKSUM_EN
                        r_xor <= r_xor ^ rx_data;
                        if (w_last)
                            r_state <= S_CHK;
`else
                        if (w_last) begin
                            r_wr       <= 1'b1;
                            r_ch       <= r_addr[CH_W-1:0];
                            r_data     <= w_asm;
                            r_ack_addr <= r_addr;
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                        end
`endif
                    end
`ifdef SYSMON_RX_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_data == r_xor) begin
                            r_wr       <= 1'b1;
                            r_ch       <= r_addr[CH_W-1:0];
                            r_data     <= r_asm;
                            r_ack_addr <= r_addr;
                        end else begin
                            r_err      <= sat_inc8(r_err);
                        end
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (w_expire) begin
                r_err   <= sat_inc8(r_err);
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign ch_wr         = r_wr;
    assign ack_valid     = r_wr;
    assign ch_wr_channel = r_ch;
    assign ch_wr_data    = r_data;
    assign ack_addr      = r_ack_addr;
    assign busy          = r_busy;
    assign err_count     = r_err;

endmodule

// File: tb/tb_system_monitor_rx_dispatcher.sv
// Scoreboard bench for system_monitor_rx_dispatcher (NUM_CH=8, DATA_W=32,
// short timeout). Works with SYSMON_RX_CHECKSUM_EN defined or not.
module tb_system_monitor_rx_dispatcher;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        ch_wr;
    logic [2:0]  ch_wr_channel;
    logic [31:0] ch_wr_data;
    logic        ack_valid;
    logic [6:0]  ack_addr;
    logic        busy;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    system_monitor_rx_dispatcher #(.NUM_CH(8), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .ch_wr         (ch_wr),
        .ch_wr_channel (ch_wr_channel),
        .ch_wr_data    (ch_wr_data),
        .ack_valid     (ack_valid),
        .ack_addr      (ack_addr),
        .busy          (busy),
        .err_count     (err_count)
    );

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] data;
        logic [6:0]  addr;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_wr   = 0;
    int   n_exp  = 0;
    int   exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        if (reset_n && (ch_wr || ack_valid)) begin
            exp_t e;
            n_wr++;
            chk("ack_eq_wr", {31'b0, ack_valid}, {31'b0, ch_wr});
            if (q.size() == 0) begin
                chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("wr_channel", {29'b0, ch_wr_channel}, {29'b0, e.ch});
                chk("wr_data", ch_wr_data, e.data);
                chk("ack_addr", {25'b0, ack_addr}, {25'b0, e.addr});
            end
        end
    end

    // Inputs change 1ns after the rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_wr(input logic [2:0] ch, input logic [31:0] d);
        exp_t e;
        e.ch = ch; e.data = d; e.addr = {4'b0, ch};
        q.push_back(e);
        n_exp++;
    endtask

    // Sends a full frame; bad_chk corrupts the checksum byte when enabled.
    task automatic frame(input logic [7:0] a, input logic [31:0] d, input logic bad_chk);
        logic [7:0] x;
        x = a;
        send(8'hA5);
        send(a);
        for (int i = 0; i < 4; i++) begin
            x = x ^ d[i*8 +: 8];
            send(d[i*8 +: 8]);
        end
`ifdef SYSMON_RX_CHECKSUM_EN
        send(bad_chk ? (x ^ 8'h0F) : x);
`else
        if (bad_chk) x = 8'h00;
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"},   {31'b0, ch_wr}, 32'd0);
        chk({tag, "_ack"},  {31'b0, ack_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_ch"},   {29'b0, ch_wr_channel}, 32'd0);
        chk({tag, "_data"}, ch_wr_data, 32'd0);
        chk({tag, "_aaddr"},{25'b0, ack_addr}, 32'd0);
        chk({tag, "_err"},  {24'b0, err_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_all_zero("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // Basic frame; strobe visible the cycle after the last byte.
        expect_wr(3'd3, 32'h44332211);
        frame(8'h03, 32'h44332211, 1'b0);
        chk("lat_wr", {31'b0, ch_wr}, 32'd1);
        chk("lat_busy", {31'b0, busy}, 32'd0);
        idle(1);
        chk("pulse_1cyc", {31'b0, ch_wr}, 32'd0);
        chk("hold_data", ch_wr_data, 32'h44332211);
        chk("err0", {24'b0, err_count}, 32'd0);

`ifdef SYSMON_RX_CHECKSUM_EN
        // Bad checksum: rejected.
        frame(8'h03, 32'h44332211, 1'b1);
        exp_err++;
        idle(2);
        chk("badchk_err", {24'b0, err_count}, 32'(exp_err));
        chk("badchk_busy", {31'b0, busy}, 32'd0);
`endif

        // Address rejects: 9, bit7 set, and 8 (first code past the last channel).
        send(8'hA5); send(8'h09); exp_err++;
        send(8'hA5); send(8'h83); exp_err++;
        send(8'hA5); send(8'h08); exp_err++;
        idle(2);
        chk("badaddr_err", {24'b0, err_count}, 32'(exp_err));
        chk("badaddr_busy", {31'b0, busy}, 32'd0);
        expect_wr(3'd0, 32'hDEADBEEF);
        frame(8'h00, 32'hDEADBEEF, 1'b0);
        expect_wr(3'd7, 32'h87654321);
        frame(8'h07, 32'h87654321, 1'b0);
        idle(2);

        // Stray byte in IDLE is ignored.
        send(8'h33);
        idle(1);
        chk("stray_busy", {31'b0, busy}, 32'd0);
        chk("stray_err", {24'b0, err_count}, 32'(exp_err));

        // Timeout: last byte at edge E; abort lands on edge E+TO.
        send(8'hA5); send(8'h05); send(8'hAA);
        idle(TO - 1);
        chk("to_busy_before", {31'b0, busy}, 32'd1);
        chk("to_err_before", {24'b0, err_count}, 32'(exp_err));
        idle(1);
        exp_err++;
        chk("to_busy_after", {31'b0, busy}, 32'd0);
        chk("to_err_after", {24'b0, err_count}, 32'(exp_err));
        expect_wr(3'd5, 32'hCAFEF00D);
        frame(8'h05, 32'hCAFEF00D, 1'b0);
        idle(2);

        // Back-to-back frames, second SYNC right after the first commit.
        expect_wr(3'd6, 32'h01020304);
        frame(8'h06, 32'h01020304, 1'b0);
        expect_wr(3'd2, 32'hA5A50000);
        frame(8'h02, 32'hA5A50000, 1'b0);
        idle(2);

        // 0xA5 payload is data, not resync.
        expect_wr(3'd1, 32'hA5A5A5A5);
        frame(8'h01, 32'hA5A5A5A5, 1'b0);
        idle(2);
        chk("err_mid", {24'b0, err_count}, 32'(exp_err));

        // Reset mid-frame: outputs drop immediately, no write afterwards.
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        send(8'h33); send(8'h44);
        idle(3);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_err", {24'b0, err_count}, 32'd0);

        // Error counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            send(8'hA5); send(8'h09);
        end
        idle(1);
        chk("err_sat", {24'b0, err_count}, 32'd255);

        idle(3);
        chk("wr_count", 32'(n_wr), 32'(n_exp));
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/system_monitor_rx_dispatcher.md
Name: system_monitor_rx_dispatcher

Overview:
Receive-side counterpart of the system monitor TX arbiter. It parses the byte stream from the ESP32 UART receiver into addressed frames and validates each frame. Each valid frame's payload is dispatched as a single-cycle register write to one of NUM_CH monitor channels. On commit it also pulses an ack carrying the 7-bit address, so the TX side can echo or refresh that channel.

Parameters:
NUM_CH, 8, number of addressable channels; valid addresses are 0..NUM_CH-1
DATA_W, 32, payload width per frame; must be a multiple of 8, so NBYTES = DATA_W/8
TIMEOUT_CYC, 50000, idle cycles allowed between bytes inside a frame before the frame is aborted

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx_data  in  8  received byte from the UART RX
rx_valid  in  1  one-cycle strobe: rx_data is valid; there is no backpressure
ch_wr  out  1  one-cycle write strobe to the channel register file
ch_wr_channel  out  $clog2(NUM_CH)  target channel of ch_wr
ch_wr_data  out  DATA_W  payload, assembled little-endian (first payload byte goes to bits [7:0])
ack_valid  out  1  one-cycle pulse, coincident with ch_wr
ack_addr  out  7  address of the committed frame
busy  out  1  high while the FSM is in any state other than IDLE
err_count  out  8  saturating count of rejected or aborted frames

Behaviour:
- Reset (async assert, sync release) clears all outputs:
  - ch_wr, ack_valid, busy all 0; ch_wr_channel, ch_wr_data, ack_addr, err_count all 0.
  - FSM returns to IDLE; byte counter and timeout counter cleared.
- Frame format: SYNC 0xA5, ADDR {1'b0, addr[6:0]}, NBYTES payload bytes, then CHK (only when the optional feature is enabled).
- CHK is the XOR of ADDR and all payload bytes.
- FSM states: IDLE, ADDR, DATA, CHK.
- IDLE: rx_valid with 0xA5 moves to ADDR. Any other byte is silently ignored (no error).
- ADDR: the byte is rejected if bit7=1 or addr >= NUM_CH.
  - On reject: err_count +1, go to IDLE.
  - Otherwise: latch addr, clear the byte index, start the running XOR with the ADDR byte, go to DATA.
- DATA: each byte shifts into the assembly register at lane = byte index, and the index increments.
  - After byte NBYTES-1, go to CHK (feature on) or commit (feature off).
  - A byte equal to 0xA5 inside DATA is payload. There is no resync.
- Commit is registered on the same edge that accepts the last byte of the frame.
  - On that edge, the FSM returns to IDLE.
  - ch_wr, ack_valid, ch_wr_channel, ch_wr_data and ack_addr are updated on that edge; ch_wr and ack_valid are high for exactly one cycle.
  - Latency: the strobe is visible in the cycle after the last byte's rx_valid.
- ch_wr_data and ch_wr_channel hold their values until the next commit. ack_addr holds until the next commit.
- A byte arriving in the cycle immediately after a commit is handled in IDLE; no bytes are lost.
- Timeout: the counter runs while not in IDLE and clears on every rx_valid.
  - When it reaches TIMEOUT_CYC-1 without a byte, go to IDLE and increment err_count.
  - If rx_valid arrives in that same cycle, the byte wins: it is processed normally and there is no timeout.
- err_count saturates at 255; it never wraps.
- Reset mid-frame discards the partial frame. No write and no error count result.
- NUM_CH values that are not a power of 2 are legal. The addr >= NUM_CH check covers the unused codes.

Optional Feature:
SYSMON_RX_CHECKSUM_EN
- Defined:
  - The CHK state exists.
  - If the received byte equals the running XOR, commit.
  - Otherwise err_count +1, no ch_wr or ack, go to IDLE.
  - Frame length is 3+NBYTES bytes.
- Undefined:
  - No CHK state and no XOR logic.
  - Commit happens on the last payload byte.
  - Frame length is 2+NBYTES bytes.

Decomposition:
- Shared package sysmon_pkg holds:
  - SYSMON_SYNC = 8'hA5;
  - the state enum typedef (IDLE/ADDR/DATA/CHK);
  - the addr field width constant (7), also used by the TX arbiter's tx_address.
- One natural sub-module: sysmon_rx_timeout. It is a loadable down-counter with inputs enable and kick, and output expire.
- The FSM, byte assembly and error counter stay in the top module.

Test Plan:
- Checksum on, NUM_CH=8, DATA_W=32. Send A5 03 11 22 33 44 then CHK=03^11^22^33^44=0x47 -> one-cycle ch_wr, ch_wr_channel=3, ch_wr_data=0x44332211, ack_addr=3, err_count=0.
- Same frame but CHK=0x48 -> no ch_wr and no ack; err_count=1; busy returns to 0.
- Send A5 09 (addr >= NUM_CH), then separately A5 83 (bit7 set) -> err_count=2, no writes; a following valid frame to addr 0 still commits.
- Send A5 05 AA, then no bytes for TIMEOUT_CYC cycles -> busy falls to 0 and err_count +1. A fresh valid frame then commits correctly.
- Two valid frames back-to-back, with the second SYNC in the cycle after the first frame's last byte -> two ch_wr pulses with the correct channels and data.
- Checksum off: A5 01 A5 A5 A5 A5 -> ch_wr with data 0xA5A5A5A5, channel 1 (0xA5 is not treated as resync). Assert reset_n low mid-frame -> all outputs 0 immediately and no write.
